battle_sequencer: RTL and testbench

- Game-flow controller for the battleship core. It sequences the phases in order: player placing, IA placing, player shoot, IA shoot, game over.
- Drives play_status, dimension, direction, we and new_value into the cell memory (cell_io).
- Walks the fixed fleet 5,4,3,3,2. Counts hits on each side and declares the winner.

---
 rtl/battle_pkg.sv | 49 ++++
 rtl/battle_sequencer_fleet_rom.sv | 14 +
 rtl/battle_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_battle_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// Shared constants, state encoding and helper functions for the battleship game-flow controller.
package battle_pkg;

    // Turn codes presented on play_status
    localparam logic [1:0] TURN_P_PLACE  = 2'd0;
    localparam logic [1:0] TURN_IA_PLACE = 2'd1;
    localparam logic [1:0] TURN_P_SHOOT  = 2'd2;
    localparam logic [1:0] TURN_IA_SHOOT = 2'd3;

    // Cell memory values
    localparam logic [4:0] CELL_EMPTY   = 5'd0;
    localparam logic [4:0] CELL_PREVIEW = 5'd1;
    localparam logic [4:0] CELL_SHIP    = 5'd2;
    localparam logic [4:0] CELL_INVALID = 5'd3;
    localparam logic [4:0] CELL_MISS    = 5'd4;
    localparam logic [4:0] CELL_HIT     = 5'd5;

    // Fleet definition: 5,4,3,3,2 -> 17 cells to sink
    localparam int FLEET_SIZE = 5;
    localparam int HIT_TARGET = 17;

    typedef enum logic [2:0] {
        S_P_PLACE,
        S_P_CHECK,
        S_IA_PLACE,
        S_P_SHOOT,
        S_P_RESULT,
        S_IA_SHOOT,
        S_OVER
    } state_t;

    // Ship length for a given fleet index; out-of-range indices give 0
    function automatic logic [3:0] fleet_dim(input logic [2:0] idx);
        case (idx)
            3'd0:    fleet_dim = 4'd5;
            3'd1:    fleet_dim = 4'd4;
            3'd2:    fleet_dim = 4'd3;
            3'd3:    fleet_dim = 4'd3;
            3'd4:    fleet_dim = 4'd2;
            default: fleet_dim = 4'd0;
        endcase
    endfunction

    // Increment that sticks at the limit instead of wrapping
    function automatic logic [4:0] sat_inc(input logic [4:0] v, input logic [4:0] lim);
        sat_inc = (v >= lim) ? lim : v + 5'd1;
    endfunction

endpackage

// File: rtl/battle_sequencer_fleet_rom.sv
// Combinational ship index to ship length lookup.
module fleet_rom
    import battle_pkg::*;
(
    input  logic [2:0] idx_i,
    output logic [3:0] dim_o
);

    // Pure table lookup
    always_comb begin
        dim_o = fleet_dim(idx_i);
    end

endmodule

// File: rtl/battle_sequencer.sv
// Game-flow controller: player placement, IA placement, alternating shots, game over.
module battle_sequencer #(
    parameter int FLEET_SIZE = 5,
    parameter int HIT_TARGET = 17,
    parameter int CLICK_WAIT = 1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       click,
    input  logic       rotate,
    input  logic       ship_placed,
    input  logic       ia_ship_placed,
    input  logic       ia_shot_done,
    input  logic       ia_hit,
    input  logic [4:0] target_status,
    output logic [1:0] play_status,
    output logic [1:0] turn_player_placing,
    output logic [1:0] turn_ia_placing,
    output logic [1:0] turn_player_shoot,
    output logic [1:0] turn_ia_shoot,
    output logic [3:0] dimension,
    output logic       direction,
    output logic       we,
    output logic [4:0] new_value,
    output logic [2:0] ship_idx,
    output logic [4:0] player_hits,
    output logic [4:0] ia_hits,
    output logic       game_over,
    output logic       winner
);

    import battle_pkg::*;

    localparam logic [2:0] LAST_IDX = 3'(FLEET_SIZE - 1);
    localparam logic [4:0] HIT_LIM  = 5'(HIT_TARGET);
    localparam logic [3:0] WAIT_END = 4'(CLICK_WAIT);

    state_t     state_q;
    logic [1:0] play_status_q;
    logic [2:0] ship_idx_q, ship_idx_d;
    logic [3:0] dimension_q;
    logic [3:0] rom_dim;
    logic       direction_q;
    logic       we_q;
    logic [4:0] new_value_q;
    logic [4:0] player_hits_q, player_hits_d;
    logic [4:0] ia_hits_q, ia_hits_d;
    logic       game_over_q;
    logic       winner_q;
    logic [2:0] ia_cnt_q;
    logic [3:0] wait_cnt_q;
    logic       shot_hit_q;
    logic       wait_done;

    assign wait_done = (wait_cnt_q == WAIT_END);

    // Next ship index, so the dimension lookup lands on the same edge as the index
    always_comb begin
        ship_idx_d = ship_idx_q;
        if (state_q == S_P_CHECK && wait_done && ship_placed) begin
            ship_idx_d = (ship_idx_q == LAST_IDX) ? 3'd0 : ship_idx_q + 3'd1;
        end
    end

    // Candidate hit totals for the resolving states
    always_comb begin
        player_hits_d = shot_hit_q ? sat_inc(player_hits_q, HIT_LIM) : player_hits_q;
        ia_hits_d     = ia_hit ? sat_inc(ia_hits_q, HIT_LIM) : ia_hits_q;
    end

    fleet_rom u_fleet_rom (
        .idx_i (ship_idx_d),
        .dim_o (rom_dim)
    );

    // Game-flow state machine with registered outputs
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= S_P_PLACE;
            play_status_q <= TURN_P_PLACE;
            ship_idx_q    <= 3'd0;
            dimension_q   <= 4'd5;
            direction_q   <= 1'b0;
            we_q          <= 1'b0;
            new_value_q   <= CELL_EMPTY;
            player_hits_q <= 5'd0;
            ia_hits_q     <= 5'd0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
            ia_cnt_q      <= 3'd0;
            wait_cnt_q    <= 4'd0;
            shot_hit_q    <= 1'b0;
        end else begin
            // Write strobe and its value are single-cycle by default
            we_q        <= 1'b0;
            new_value_q <= CELL_EMPTY;
            ship_idx_q  <= ship_idx_d;
            dimension_q <= rom_dim;
            case (state_q)
                S_P_PLACE: begin
                    if (click) begin
                        we_q       <= 1'b1;
                        wait_cnt_q <= 4'd0;
                        state_q    <= S_P_CHECK;
                    end else if (rotate) begin
                        direction_q <= ~direction_q;
                    end
                end
                S_P_CHECK: begin
                    if (!wait_done) begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end else if (ship_placed && ship_idx_q == LAST_IDX) begin
                        state_q       <= S_IA_PLACE;
                        play_status_q <= TURN_IA_PLACE;
                        direction_q   <= 1'b0;
                        ia_cnt_q      <= 3'd0;
                    end else begin
                        state_q <= S_P_PLACE;
                    end
                end
                S_IA_PLACE: begin
                    if (ia_ship_placed) begin
                        if (ia_cnt_q == LAST_IDX) begin
                            state_q       <= S_P_SHOOT;
                            play_status_q <= TURN_P_SHOOT;
                        end else begin
                            ia_cnt_q <= ia_cnt_q + 3'd1;
                        end
                    end
                end
                S_P_SHOOT: begin
                    // Cells already shot (miss/hit) do not accept another shot
                    if (click && target_status != CELL_MISS && target_status != CELL_HIT) begin
                        we_q        <= 1'b1;
                        new_value_q <= (target_status == CELL_SHIP) ? CELL_HIT : CELL_MISS;
                        shot_hit_q  <= (target_status == CELL_SHIP);
                        state_q     <= S_P_RESULT;
                    end
                end
                S_P_RESULT: begin
                    player_hits_q <= player_hits_d;
                    if (player_hits_d == HIT_LIM) begin
                        state_q     <= S_OVER;
                        game_over_q <= 1'b1;
                        winner_q    <= 1'b0;
                    end else begin
                        state_q       <= S_IA_SHOOT;
                        play_status_q <= TURN_IA_SHOOT;
                    end
                end
                S_IA_SHOOT: begin
                    if (ia_shot_done) begin
                        ia_hits_q <= ia_hits_d;
                        if (ia_hits_d == HIT_LIM) begin
                            state_q     <= S_OVER;
                            game_over_q <= 1'b1;
                            winner_q    <= 1'b1;
                        end else begin
                            state_q       <= S_P_SHOOT;
                            play_status_q <= TURN_P_SHOOT;
                        end
                    end
                end
                S_OVER: begin
                    state_q <= S_OVER;
                end
                default: begin
                    state_q <= S_P_PLACE;
                end
            endcase
        end
    end

    assign play_status         = play_status_q;
    assign turn_player_placing = TURN_P_PLACE;
    assign turn_ia_placing     = TURN_IA_PLACE;
    assign turn_player_shoot   = TURN_P_SHOOT;
    assign turn_ia_shoot       = TURN_IA_SHOOT;
    assign dimension           = dimension_q;
    assign direction           = direction_q;
    assign we                  = we_q;
    assign new_value           = new_value_q;
    assign ship_idx            = ship_idx_q;
    assign player_hits         = player_hits_q;
    assign ia_hits             = ia_hits_q;
    assign game_over           = game_over_q;
    assign winner              = winner_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Directed bench for battle_sequencer with a write-strobe scoreboard.
module tb_battle_sequencer;

    localparam int CW = 1;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       click = 1'b0;
    logic       rotate = 1'b0;
    logic       ship_placed = 1'b0;
    logic       ia_ship_placed = 1'b0;
    logic       ia_shot_done = 1'b0;
    logic       ia_hit = 1'b0;
    logic [4:0] target_status = 5'd0;
    logic [1:0] play_status, t_pp, t_ip, t_ps, t_is;
    logic [3:0] dimension;
    logic       direction, we, game_over, winner;
    logic [4:0] new_value, player_hits, ia_hits;
    logic [2:0] ship_idx;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];
    logic prev_we = 1'b0;
    int dims[5] = '{5, 4, 3, 3, 2};

    battle_sequencer #(.FLEET_SIZE(5), .HIT_TARGET(17), .CLICK_WAIT(CW)) dut (
        .clk_in(clk_in), .reset(reset), .click(click), .rotate(rotate),
        .ship_placed(ship_placed), .ia_ship_placed(ia_ship_placed),
        .ia_shot_done(ia_shot_done), .ia_hit(ia_hit), .target_status(target_status),
        .play_status(play_status), .turn_player_placing(t_pp), .turn_ia_placing(t_ip),
        .turn_player_shoot(t_ps), .turn_ia_shoot(t_is), .dimension(dimension),
        .direction(direction), .we(we), .new_value(new_value), .ship_idx(ship_idx),
        .player_hits(player_hits), .ia_hits(ia_hits), .game_over(game_over), .winner(winner)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every write strobe must be expected, isolated, and carry the queued value
    always @(negedge clk_in) begin
        logic [4:0] e;
        if (we === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0 && prev_we !== 1'b1) else begin
                n_err++;
                $error("FAIL we_strobe: observed we=1 (prev_we %0b, pending %0d) expected no strobe",
                       prev_we, exp_q.size());
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("new_value", 32'(new_value), 32'(e));
            end
        end
        prev_we = we;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_rotate();
        rotate = 1'b1;
        step();
        rotate = 1'b0;
    endtask

    task automatic place(input logic acc);
        ship_placed = acc;
        exp_q.push_back(5'd0);
        click = 1'b1;
        step();
        click = 1'b0;
        repeat (CW + 1) step();
        ship_placed = 1'b0;
    endtask

    task automatic ia_place_n(input int n);
        for (int k = 0; k < n; k++) begin
            ia_ship_placed = 1'b1;
            step();
            ia_ship_placed = 1'b0;
            step();
        end
    endtask

    task automatic shoot(input logic [4:0] ts);
        target_status = ts;
        if (ts != 5'd4 && ts != 5'd5) exp_q.push_back((ts == 5'd2) ? 5'd5 : 5'd4);
        click = 1'b1;
        step();
        click = 1'b0;
        step();
        target_status = 5'd0;
    endtask

    task automatic ia_shot(input logic h);
        ia_shot_done = 1'b1;
        ia_hit = h;
        step();
        ia_shot_done = 1'b0;
        ia_hit = 1'b0;
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_play_status"}, 32'(play_status), 0);
        chk({pfx, "_ship_idx"}, 32'(ship_idx), 0);
        chk({pfx, "_dimension"}, 32'(dimension), 5);
        chk({pfx, "_direction"}, 32'(direction), 0);
        chk({pfx, "_we"}, 32'(we), 0);
        chk({pfx, "_new_value"}, 32'(new_value), 0);
        chk({pfx, "_player_hits"}, 32'(player_hits), 0);
        chk({pfx, "_ia_hits"}, 32'(ia_hits), 0);
        chk({pfx, "_game_over"}, 32'(game_over), 0);
        chk({pfx, "_winner"}, 32'(winner), 0);
    endtask

    initial begin
        step();
        do_reset();
        chk_reset_state("rst");
        chk("turn_pp", 32'(t_pp), 0);
        chk("turn_ip", 32'(t_ip), 1);
        chk("turn_ps", 32'(t_ps), 2);
        chk("turn_is", 32'(t_is), 3);

        // Rotation toggles
        pulse_rotate();
        chk("rot1", 32'(direction), 1);
        pulse_rotate();
        chk("rot2", 32'(direction), 0);

        // Accepted placement with simultaneous rotate (rotate loses)
        ship_placed = 1'b1;
        exp_q.push_back(5'd0);
        click = 1'b1;
        rotate = 1'b1;
        step();
        click = 1'b0;
        rotate = 1'b0;
        chk("place_we_hi", 32'(we), 1);
        chk("click_rot_dir", 32'(direction), 0);
        step();
        chk("place_we_lo", 32'(we), 0);
        step();
        ship_placed = 1'b0;
        chk("place_idx1", 32'(ship_idx), 1);
        chk("place_dim4", 32'(dimension), 4);

        // Rejected placement; a click during the check is dropped
        exp_q.push_back(5'd0);
        click = 1'b1;
        step();
        click = 1'b0;
        step();
        click = 1'b1;
        step();
        click = 1'b0;
        chk("reject_idx", 32'(ship_idx), 1);
        chk("reject_we", 32'(we), 0);
        step();

        // Remaining fleet, direction cleared on leaving placement
        for (int i = 1; i < 5; i++) begin
            chk("fleet_dim", 32'(dimension), 32'(dims[i]));
            if (i == 4) begin
                pulse_rotate();
                chk("last_rot", 32'(direction), 1);
            end
            place(1'b1);
        end
        chk("ia_place_status", 32'(play_status), 1);
        chk("ia_place_idx", 32'(ship_idx), 0);
        chk("ia_place_dim", 32'(dimension), 5);
        chk("ia_place_dir", 32'(direction), 0);

        // IA placement ignores click/rotate and needs five pulses
        click = 1'b1;
        rotate = 1'b1;
        step();
        click = 1'b0;
        rotate = 1'b0;
        chk("ia_place_nowe", 32'(we), 0);
        chk("ia_place_norot", 32'(direction), 0);
        ia_place_n(4);
        chk("ia_place_4", 32'(play_status), 1);
        ia_place_n(1);
        chk("ia_place_5", 32'(play_status), 2);

        // First player shot hits
        shoot(5'd2);
        chk("shot1_hits", 32'(player_hits), 1);
        chk("shot1_status", 32'(play_status), 3);
        chk("shot1_nv_clear", 32'(new_value), 0);

        // ia_hit alone does nothing; then a real IA hit
        ia_hit = 1'b1;
        step();
        ia_hit = 1'b0;
        chk("ia_hit_alone", 32'(ia_hits), 0);
        chk("ia_hit_alone_st", 32'(play_status), 3);
        ia_shot(1'b1);
        chk("ia_shot1_hits", 32'(ia_hits), 1);
        chk("ia_shot1_status", 32'(play_status), 2);

        // Already-shot cells are refused
        shoot(5'd5);
        chk("reshoot5_we", 32'(we), 0);
        chk("reshoot5_st", 32'(play_status), 2);
        shoot(5'd4);
        chk("reshoot4_st", 32'(play_status), 2);

        // A miss
        shoot(5'd0);
        chk("miss_hits", 32'(player_hits), 1);
        chk("miss_status", 32'(play_status), 3);
        ia_shot(1'b0);
        chk("ia_miss_hits", 32'(ia_hits), 1);

        // Player sinks the whole fleet
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("pre_over", 32'(game_over), 0);
            shoot(5'd2);
            if (i < 15) ia_shot(1'b0);
        end
        chk("pwin_hits", 32'(player_hits), 17);
        chk("pwin_over", 32'(game_over), 1);
        chk("pwin_winner", 32'(winner), 0);
        chk("pwin_status", 32'(play_status), 2);

        // Game over is sticky and silent
        target_status = 5'd2;
        click = 1'b1;
        step();
        click = 1'b0;
        target_status = 5'd0;
        chk("over_we", 32'(we), 0);
        ia_shot(1'b1);
        chk("over_ia_hits", 32'(ia_hits), 1);
        chk("over_sticky", 32'(game_over), 1);

        do_reset();
        chk_reset_state("rst2");

        // IA wins a full game
        for (int i = 0; i < 5; i++) place(1'b1);
        ia_place_n(5);
        for (int i = 0; i < 17; i++) begin
            shoot(5'd0);
            ia_shot(1'b1);
        end
        chk("iawin_hits", 32'(ia_hits), 17);
        chk("iawin_phits", 32'(player_hits), 0);
        chk("iawin_over", 32'(game_over), 1);
        chk("iawin_winner", 32'(winner), 1);
        chk("iawin_status", 32'(play_status), 3);

        // Reset in the middle of a placement check
        do_reset();
        pulse_rotate();
        place(1'b1);
        chk("mid_pre_idx", 32'(ship_idx), 1);
        chk("mid_pre_dir", 32'(direction), 1);
        ship_placed = 1'b1;
        exp_q.push_back(5'd0);
        click = 1'b1;
        step();
        click = 1'b0;
        chk("mid_we", 32'(we), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        ship_placed = 1'b0;
        chk_reset_state("midrst");

        step();
        chk("pending_we", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
